// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the 8x16 register file clients.
//   DATA_W / NREGS / AW : operand width, register count, register index width
//   reg_idx_t, word_t    : register index and data word
//   op_bundle_t          : operand bundle held by operand_fetch's output stage
//   of_state_t           : operand_fetch output-stage state
package regfile_pkg;

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int AW     = 3;

    typedef logic [AW-1:0]     reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef struct packed {
        word_t    a;
        word_t    b;
        reg_idx_t rd;
        logic     wr_rd;
    } op_bundle_t;

    typedef enum logic {
        OF_EMPTY = 1'b0,
        OF_FULL  = 1'b1
    } of_state_t;

endpackage

// File: rtl/op_scoreboard.sv
// op_scoreboard: per-register busy bits for pending writes.
//   clk, rst_n          : clock, asynchronous active-low reset (clears all bits)
//   clr_en, clr_idx     : writeback completed for clr_idx
//   set_en, set_idx     : an issued instruction will write set_idx
//   rs1, rs2, rd        : lookup indices
//   busy_rs1/rs2/rd     : registered busy state of the looked-up registers
// When a clear and a set hit the same index in one cycle the set wins, since
// the newly issued writer is younger than the one completing.
module op_scoreboard
    import regfile_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_idx,
    input  logic          set_en,
    input  logic [AW-1:0] set_idx,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic [AW-1:0] rd,
    output logic          busy_rs1,
    output logic          busy_rs2,
    output logic          busy_rd
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy_q;
        if (clr_en) busy_nxt[clr_idx] = 1'b0;
        if (set_en) busy_nxt[set_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_nxt;
    end

    assign busy_rs1 = busy_q[rs1];
    assign busy_rs2 = busy_q[rs2];
    assign busy_rd  = busy_q[rd];

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: read-side client of the 8x16 register file.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_valid/in_ready           : decoded instruction handshake
//   in_rs1/in_rs2, in_use_rs1/2 : source indices and whether each is read
//   in_rd, in_wr_rd             : destination index and write flag
//   reg_a/reg_b, rd_a/rd_b      : regfile read addresses / combinational data
//   wb_valid, wb_reg, wb_data   : writeback strobe (same as regfile write)
//   op_valid/op_ready           : operand bundle handshake
//   op_a/op_b, op_rd, op_wr_rd  : captured operands and forwarded destination
// Optional feature macro: OPERAND_FETCH_BYPASS_EN forwards the same-cycle
// writeback data to a dependent source so it issues without a stall cycle.
module operand_fetch
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_rs1,
    input  logic [AW-1:0]     in_rs2,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic [AW-1:0]     in_rd,
    input  logic              in_wr_rd,
    output logic [AW-1:0]     reg_a,
    output logic [AW-1:0]     reg_b,
    input  logic [DATA_W-1:0] rd_a,
    input  logic [DATA_W-1:0] rd_b,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [AW-1:0]     op_rd,
    output logic              op_wr_rd
);

    of_state_t  state_q, state_nxt;
    op_bundle_t bundle_q;

    logic busy_rs1, busy_rs2, busy_rd;
    logic byp1, byp2;
    logic hazard1, hazard2, waw;
    logic space, issue;

    assign reg_a = in_rs1;
    assign reg_b = in_rs2;

`ifdef OPERAND_FETCH_BYPASS_EN
    assign byp1 = in_use_rs1 & wb_valid & (wb_reg == in_rs1);
    assign byp2 = in_use_rs2 & wb_valid & (wb_reg == in_rs2);
`else
    // Without forwarding the consumer waits one cycle and reads the regfile
    // after the negedge write has landed.
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign space   = (state_q == OF_EMPTY) | op_ready;
    assign hazard1 = in_use_rs1 & busy_rs1 & ~byp1;
    assign hazard2 = in_use_rs2 & busy_rs2 & ~byp2;
    // The completing writeback frees the slot for a new writer of the same reg.
    assign waw     = in_wr_rd & busy_rd & ~(wb_valid & (wb_reg == in_rd));
    // rst_n gates issue so nothing is accepted while reset is held.
    assign issue   = rst_n & in_valid & space & ~hazard1 & ~hazard2 & ~waw;
    assign in_ready = issue;

    op_scoreboard u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_en   (wb_valid),
        .clr_idx  (wb_reg),
        .set_en   (issue & in_wr_rd),
        .set_idx  (in_rd),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .rd       (in_rd),
        .busy_rs1 (busy_rs1),
        .busy_rs2 (busy_rs2),
        .busy_rd  (busy_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= OF_EMPTY;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            OF_EMPTY: if (issue) state_nxt = OF_FULL;
            OF_FULL:  if (op_ready && !issue) state_nxt = OF_EMPTY;
            default:  state_nxt = OF_EMPTY;
        endcase
    end

    // Bundle loads only on issue; issue implies space, so a held bundle
    // stays stable while op_ready is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_q <= '0;
        end else if (issue) begin
            bundle_q.a     <= byp1 ? wb_data : rd_a;
            bundle_q.b     <= byp2 ? wb_data : rd_b;
            bundle_q.rd    <= in_rd;
            bundle_q.wr_rd <= in_wr_rd;
        end
    end

    assign op_valid = (state_q == OF_FULL);
    assign op_a     = bundle_q.a;
    assign op_b     = bundle_q.b;
    assign op_rd    = bundle_q.rd;
    assign op_wr_rd = bundle_q.wr_rd;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed steps plus randomized traffic for operand_fetch,
// checked against a pending-write/regfile reference model.
module tb_operand_fetch;
    import regfile_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [AW-1:0] in_rs1, in_rs2, in_rd;
    logic          in_use_rs1, in_use_rs2, in_wr_rd;
    logic [AW-1:0] reg_a, reg_b;
    word_t         rd_a, rd_b;
    logic          wb_valid;
    logic [AW-1:0] wb_reg;
    word_t         wb_data;
    logic          op_valid, op_ready;
    word_t         op_a, op_b;
    logic [AW-1:0] op_rd;
    logic          op_wr_rd;

    int vectors = 0;
    int miscompares = 0;

    // register file: written on negedge, read combinationally
    word_t rf [NREGS];
    always @(negedge clk) if (wb_valid) rf[wb_reg] <= wb_data;
    assign rd_a = rf[reg_a];
    assign rd_b = rf[reg_b];

    // reference model
    bit [NREGS-1:0] m_busy;
    bit             m_valid;
    word_t          m_a, m_b;
    logic [AW-1:0]  m_rd;
    bit             m_wr;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_rd(in_rd), .in_wr_rd(in_wr_rd),
        .reg_a(reg_a), .reg_b(reg_b), .rd_a(rd_a), .rd_b(rd_b),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_wr_rd(op_wr_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input bit v, input int rs1, input bit u1, input int rs2,
                             input bit u2, input int rd, input bit wr);
        in_valid = v; in_rs1 = AW'(rs1); in_use_rs1 = u1; in_rs2 = AW'(rs2);
        in_use_rs2 = u2; in_rd = AW'(rd); in_wr_rd = wr;
    endtask

    task automatic set_wb(input bit v, input int r, input word_t d);
        wb_valid = v; wb_reg = AW'(r); wb_data = d;
    endtask

    // Called 1 time unit after a posedge with inputs settled. Checks the
    // combinational outputs late in the cycle, advances the model at the
    // edge, then checks the registered outputs just after it.
    // force_rdy >= 0 adds a directed check of in_ready against that constant.
    task automatic cycle(input int force_rdy);
        bit b1, b2, exp_rdy;
        word_t na, nb;
        #7;
        b1 = 1'b0; b2 = 1'b0;
`ifdef OPERAND_FETCH_BYPASS_EN
        b1 = in_use_rs1 && wb_valid && wb_reg == in_rs1;
        b2 = in_use_rs2 && wb_valid && wb_reg == in_rs2;
`endif
        exp_rdy = rst_n && in_valid && (!m_valid || op_ready)
                  && !(in_use_rs1 && m_busy[in_rs1] && !b1)
                  && !(in_use_rs2 && m_busy[in_rs2] && !b2)
                  && !(in_wr_rd && m_busy[in_rd] && !(wb_valid && wb_reg == in_rd));
        chk("in_ready", in_ready, exp_rdy);
        if (force_rdy >= 0) chk("in_ready_dir", in_ready, force_rdy[0]);
        chk("reg_a", reg_a, in_rs1);
        chk("reg_b", reg_b, in_rs2);
        na = b1 ? wb_data : rf[in_rs1];
        nb = b2 ? wb_data : rf[in_rs2];
        @(posedge clk);
        if (exp_rdy) begin
            m_valid = 1'b1; m_a = na; m_b = nb; m_rd = in_rd; m_wr = in_wr_rd;
        end else if (op_ready) begin
            m_valid = 1'b0;
        end
        if (wb_valid) m_busy[wb_reg] = 1'b0;
        if (exp_rdy && in_wr_rd) m_busy[in_rd] = 1'b1;
        #1;
        chk("op_valid", op_valid, m_valid);
        if (m_valid) begin
            chk("op_a", op_a, m_a);
            chk("op_b", op_b, m_b);
            chk("op_rd", op_rd, m_rd);
            chk("op_wr_rd", op_wr_rd, m_wr);
        end
    endtask

    task automatic model_reset();
        m_busy = '0; m_valid = 1'b0; m_a = '0; m_b = '0; m_rd = '0; m_wr = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_op_valid", op_valid, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_op_rd", op_rd, 0);
        chk("rst_op_wr_rd", op_wr_rd, 0);
        chk("rst_in_ready", in_ready, 0);
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) rf[i] = '0;
        model_reset();
        rst_n = 1'b0;
        op_ready = 1'b0;
        set_instr(1, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0, '0);

        // reset values, in_ready held low with a valid instruction present
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst_n = 1'b1;
        set_instr(0, 0, 0, 0, 0, 0, 0);

        // preload R2 and R5 via writeback to idle registers (clear is a no-op)
        set_wb(1, 2, 16'h1234); cycle(-1);
        set_wb(1, 5, 16'hBEEF); cycle(-1);
        set_wb(0, 0, '0);

        // no hazard
        set_instr(1, 2, 1, 5, 1, 3, 1); cycle(1);
        chk("nohaz_op_a", op_a, 16'h1234);
        chk("nohaz_op_b", op_b, 16'hBEEF);
        chk("nohaz_op_rd", op_rd, 3);

        // backpressure: same source on both operands waits behind a full stage
        set_instr(1, 2, 1, 2, 1, 7, 1);
        for (int i = 0; i < 5; i++) cycle(0);
        chk("bp_hold_a", op_a, 16'hBEEF ^ 16'hBEEF ^ 16'h1234);
        op_ready = 1'b1; cycle(1);
        chk("b2b_valid", op_valid, 1);
        chk("same_src_a", op_a, 16'h1234);
        chk("same_src_b", op_b, 16'h1234);
        set_instr(0, 0, 0, 0, 0, 0, 0); cycle(-1);

        // RAW on R3 (busy from the first instruction)
        op_ready = 1'b0;
        set_instr(1, 3, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0);
        set_wb(1, 3, 16'h00AA);
`ifdef OPERAND_FETCH_BYPASS_EN
        cycle(1);
        set_instr(0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0, '0);
        cycle(-1);
`else
        cycle(0);
        set_wb(0, 0, '0);
        cycle(1);
        set_instr(0, 0, 0, 0, 0, 0, 0);
`endif
        chk("raw_valid", op_valid, 1);
        chk("raw_op_a", op_a, 16'h00AA);
        op_ready = 1'b1; cycle(-1);

        // WAW on R4: issues in the writeback cycle and R4 stays busy
        set_instr(1, 0, 0, 0, 0, 4, 1); cycle(1);
        for (int i = 0; i < 2; i++) cycle(0);
        set_wb(1, 4, 16'h4444); cycle(1);
        set_wb(0, 0, '0);
        set_instr(1, 4, 1, 0, 0, 0, 0); cycle(0);
        set_wb(1, 4, 16'h5555); set_instr(0, 0, 0, 0, 0, 0, 0); cycle(-1);
        set_wb(0, 0, '0);

        // same-cycle clear of R1 and set of R6
        set_instr(1, 0, 0, 0, 0, 1, 1); cycle(1);
        set_wb(1, 1, 16'h0101); set_instr(1, 0, 0, 0, 0, 6, 1); cycle(1);
        set_wb(0, 0, '0);
        set_instr(1, 1, 1, 0, 0, 0, 0); cycle(1);
        set_instr(1, 6, 1, 0, 0, 0, 0); cycle(0);
        set_wb(1, 6, 16'h0606); set_instr(0, 0, 0, 0, 0, 0, 0); cycle(-1);
        set_wb(0, 0, '0);

        // asynchronous reset while FULL with R5 busy
        op_ready = 1'b0;
        set_instr(1, 2, 1, 2, 1, 5, 1); cycle(1);
        set_instr(1, 5, 1, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        @(posedge clk); #1;
        chk_reset_outputs();
        rst_n = 1'b1;
        model_reset();
        cycle(1);
        op_ready = 1'b1; set_instr(0, 0, 0, 0, 0, 0, 0); cycle(-1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int cand[$];
            cand = {};
            for (int r = 0; r < NREGS; r++) if (m_busy[r]) cand.push_back(r);
            set_instr($urandom_range(9, 0) < 7, $urandom_range(NREGS-1, 0), $urandom_range(1, 0),
                      $urandom_range(NREGS-1, 0), $urandom_range(1, 0),
                      $urandom_range(NREGS-1, 0), $urandom_range(1, 0));
            op_ready = ($urandom_range(3, 0) != 0);
            if (cand.size() > 0 && $urandom_range(1, 0) == 1)
                set_wb(1, cand[$urandom_range(cand.size()-1, 0)], word_t'($urandom));
            else if ($urandom_range(9, 0) == 0)
                set_wb(1, $urandom_range(NREGS-1, 0), word_t'($urandom));
            else
                set_wb(0, 0, '0);
            cycle(-1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
